// File: rtl/mult_div_unit.sv
// Radix-2 sequential signed multiply/divide unit producing the HI/LO pair.
// Multiplies by shift-add and divides by restoring division, both on operand magnitudes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start_mult / start_div
// S_MULT   | shift-add iterations, one multiplier bit per cycle
// S_DIV    | restoring-division iterations, one quotient bit per cycle
// S_FINISH | sign fix-up and HI/LO write (skipped write on divide by zero)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Multiply: a_mag is the multiplicand, b_mag shifts right as the multiplier.
    // Divide: a_mag shifts left feeding dividend bits, b_mag is the divisor.
    assign mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_mag_q};
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_mag_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, b_mag_q};

    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_mult || start_div) begin
                    a_mag_d  = mag(op_a);
                    b_mag_d  = mag(op_b);
                    sa_d     = op_a[WIDTH-1];
                    sb_d     = op_b[WIDTH-1];
                    cnt_d    = '0;
                    acc_d    = '0;
                    is_div_d = !start_mult;
                    dz_d     = !start_mult && (op_b == '0);
                    if (start_mult)
                        state_d = S_MULT;
                    else if (op_b == '0)
                        state_d = S_FINISH;
                    else
                        state_d = S_DIV;
                end
            end
            S_MULT: begin
                if (b_mag_q[0])
                    acc_d = {mult_sum, acc_q[WIDTH-1:1]};
                else
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                b_mag_d = b_mag_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST)
                    state_d = S_FINISH;
            end
            S_DIV: begin
                if (!diff[WIDTH])
                    acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                a_mag_d = a_mag_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST)
                    state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (dz_q) begin
                    div_zero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO, latency and busy length are
// queued when a request is driven and checked when done pulses.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] op_a, op_b;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
        int          busy_n;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          busy_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (div_zero && !done) check("dz_without_done", div_zero, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    check("hi", hi_out, e.hi);
                    check("lo", lo_out, e.lo);
                    check("div_zero", div_zero, e.dz);
                    check("latency", cyc, e.due);
                    check("busy_cycles", busy_cnt, e.busy_n);
                    check("busy_at_done", busy, 0);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drives a request right now (caller is already just after a rising edge).
    task automatic issue_now(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint pa, pb, p;
        start_mult = !is_div;
        start_div  = is_div;
        op_a = a;
        op_b = b;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (is_div && b == 32'd0) begin
            e.dz = 1'b1;
            e.due = cyc + 2;
            e.busy_n = 1;
        end else begin
            if (is_div) begin
                m_lo = 32'(pa / pb);
                m_hi = 32'(pa % pb);
            end else begin
                p = pa * pb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            e.dz = 1'b0;
            e.due = cyc + 34;
            e.busy_n = 33;
        end
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
    endtask

    task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        issue_now(is_div, a, b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) return;
        end
        check("idle_timeout", 64'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) return;
        end
        check("done_timeout", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start_mult = 1'b0;
        start_div = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);

        issue(0, 32'd7, 32'hFFFF_FFFD);          wait_idle();
        issue(0, 32'h8000_0000, 32'h8000_0000);  wait_idle();
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_idle();
        issue(1, 32'hFFFF_FFF9, 32'd2);          wait_idle();
        issue(1, 32'd100, 32'd7);                wait_idle();
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF);  wait_idle();
        issue(0, 32'd5, 32'd6);                  wait_idle();
        issue(1, 32'd9, 32'd0);                  wait_idle();

        for (int i = 0; i < 8; i++) begin
            issue(i[0], $urandom, (i < 4) ? $urandom_range(1, 1000) : $urandom);
            wait_idle();
        end

        // Start while busy with a different operand must be ignored.
        issue(0, 32'd7, 32'hFFFF_FFFD);
        repeat (10) @(posedge clk);
        #1 start_div = 1'b1; op_a = 32'd12345; op_b = 32'd3;
        @(posedge clk); #1 start_div = 1'b0;
        wait_idle();

        // Reset at iteration 10 aborts the operation.
        issue(0, 32'd11, 32'd13);
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("abort_hi", hi_out, 0);
        check("abort_lo", lo_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        repeat (40) @(posedge clk);
        #1 check("abort_no_done", done, 0);

        // Back-to-back: new start accepted in the done cycle.
        issue(0, 32'd3, 32'hFFFF_FFFC);
        wait_done();
        issue_now(1, 32'hFFFF_FF9C, 32'd7);
        wait_idle();
        issue(1, 32'd50, 32'hFFFF_FFF9);
        wait_idle();

        repeat (5) @(posedge clk);
        #1 check("sb_empty", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
